signed_sub_with_overflow_pipe: RTL and testbench

- Two-stage pipelined signed (two's complement) subtractor: res = a - b, with overflow detection.
- Companion to the signed adder with overflow in the arithmetic library; this is the subtract direction, pipelined for wider operands.
- The low half and its carry are computed in stage 1; the high half, the sign and the overflow are computed in stage 2.
- Keeps a sticky overflow flag and a saturating overflow event counter for software and debug visibility.

---
 rtl/signed_sub_with_overflow_pipe_pkg.sv | 11 +
 rtl/signed_sub_with_overflow_pipe_if.sv | 14 +
 rtl/signed_sub_with_overflow_pipe_half.sv | 16 +
 rtl/signed_sub_with_overflow_pipe.sv | 116 +++++++++++
 tb/tb_signed_sub_with_overflow_pipe.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/signed_sub_with_overflow_pipe_pkg.sv
// Shared arithmetic constants for the pipelined signed subtractor.
// The stage-1 bundle is W-dependent, so the top declares its struct from H.
package arith_pkg;

  // Subtraction is a + ~b + 1, so a carry-out of 1 means "no borrow".
  localparam logic CARRY_NO_BORROW = 1'b1;

  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_CW = 4;

endpackage

// File: rtl/signed_sub_with_overflow_pipe_if.sv
// Argument/result bundle for the pipelined signed subtractor.
interface signed_sub_with_overflow_pipe_if #(
  parameter int unsigned W = 8
);
  logic         arg_vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_vld;
  logic [W-1:0] res;
  logic         overflow;

  modport master (output arg_vld, a, b, input res_vld, res, overflow);
  modport slave  (input arg_vld, a, b, output res_vld, res, overflow);
endinterface

// File: rtl/signed_sub_with_overflow_pipe_half.sv
// Combinational half-width a + ~b + cin, used for both the low and high halves.
module sub_half_stage #(
  parameter int unsigned H = 4
) (
  input  logic [H-1:0] a_i,
  input  logic [H-1:0] b_i,
  input  logic         cin_i,
  output logic [H-1:0] sum_o,
  output logic         cout_o
);
  logic [H:0] full;

  assign full   = {1'b0, a_i} + {1'b0, ~b_i} + {{H{1'b0}}, cin_i};
  assign sum_o  = full[H-1:0];
  assign cout_o = full[H];
endmodule

// File: rtl/signed_sub_with_overflow_pipe.sv
// Two-stage signed subtractor: low half + borrow in stage 1, high half and
// overflow in stage 2, plus a sticky overflow flag and saturating counter.
module signed_sub_with_overflow_pipe
  import arith_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned CW = DEF_CW
) (
  input  logic                          clk,
  input  logic                          rst,
  signed_sub_with_overflow_pipe_if.slave bus,
  input  logic                          clr_sticky,
  output logic                          ovf_sticky,
  output logic [CW-1:0]                 ovf_cnt
);
  localparam int unsigned H = W / 2;

  typedef struct packed {
    logic [H-1:0] lo;
    logic         c1;
    logic [H-1:0] a_hi;
    logic [H-1:0] b_hi;
    logic         vld;
  } stage1_t;

  stage1_t s1_q, s1_d;

  logic [H-1:0]  lo_sum, hi_sum;
  logic          lo_cout, hi_cout;

  logic          vld_q, vld_d;
  logic [W-1:0]  res_q, res_d;
  logic          ovf_q, ovf_d;
  logic          sticky_q, sticky_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_event;

  sub_half_stage #(.H(H)) u_lo (
    .a_i   (bus.a[H-1:0]),
    .b_i   (bus.b[H-1:0]),
    .cin_i (CARRY_NO_BORROW),
    .sum_o (lo_sum),
    .cout_o(lo_cout)
  );

  sub_half_stage #(.H(H)) u_hi (
    .a_i   (s1_q.a_hi),
    .b_i   (s1_q.b_hi),
    .cin_i (s1_q.c1),
    .sum_o (hi_sum),
    .cout_o(hi_cout)
  );

  // Stage 1: data captured only for valid arguments, valid bit every cycle.
  always_comb begin
    s1_d     = s1_q;
    s1_d.vld = bus.arg_vld;
    if (bus.arg_vld) begin
      s1_d.lo   = lo_sum;
      s1_d.c1   = lo_cout;
      s1_d.a_hi = bus.a[W-1:H];
      s1_d.b_hi = bus.b[W-1:H];
    end
  end

  // Stage 2: result and overflow hold their value across bubbles.
  always_comb begin
    vld_d = s1_q.vld;
    res_d = res_q;
    ovf_d = ovf_q;
    if (s1_q.vld) begin
      res_d = {hi_sum, s1_q.lo};
      ovf_d = (s1_q.a_hi[H-1] != s1_q.b_hi[H-1]) && (hi_sum[H-1] != s1_q.a_hi[H-1]);
    end
  end

  // Set takes priority over clear when both land on the same edge.
  assign ovf_event = vld_q && ovf_q;

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (ovf_event) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      vld_q    <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.res_vld  = vld_q;
  assign bus.res      = res_q;
  assign bus.overflow = ovf_q;
  assign ovf_sticky   = sticky_q;
  assign ovf_cnt      = cnt_q;

  logic unused_hi_cout;
  assign unused_hi_cout = hi_cout;
endmodule

// File: tb/tb_signed_sub_with_overflow_pipe.sv
// Scoreboard bench for the pipelined signed subtractor (W=8, CW=4).
module tb_signed_sub_with_overflow_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_sticky = 1'b0;
  logic       ovf_sticky;
  logic [3:0] ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];

  signed_sub_with_overflow_pipe_if #(.W(8)) bif ();

  signed_sub_with_overflow_pipe #(.W(8), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.slave),
    .clr_sticky(clr_sticky),
    .ovf_sticky(ovf_sticky),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic o);
    @(negedge clk);
    bif.arg_vld = 1'b1;
    bif.a       = a;
    bif.b       = b;
    exp_q.push_back({o, r});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bif.arg_vld = 1'b0;
    end
  endtask

  // Monitor: every valid result must match the oldest pending expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (bif.res_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_vld", 32'(bif.res), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("res", 32'(bif.res), 32'(e[7:0]));
          chk("overflow", 32'(bif.overflow), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    logic       pat_v[6];
    logic [7:0] pat_a[6];
    logic [7:0] pat_b[6];
    logic [7:0] pat_r[6];
    logic       pat_o[6];
    int         waited;

    bif.arg_vld = 1'b0;
    bif.a       = '0;
    bif.b       = '0;

    repeat (3) @(negedge clk);
    chk("rst_res_vld", 32'(bif.res_vld), 0);
    chk("rst_res", 32'(bif.res), 0);
    chk("rst_overflow", 32'(bif.overflow), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    chk("rst_cnt", 32'(ovf_cnt), 0);
    rst = 1'b0;

    // Latency: issue before edge k, result visible after edge k+1.
    send(8'h05, 8'h03, 8'h02, 1'b0);
    idle(1);
    chk("lat_not_yet", 32'(bif.res_vld), 0);
    idle(1);
    chk("lat_two", 32'(bif.res_vld), 1);
    idle(2);
    chk("no_ovf_cnt", 32'(ovf_cnt), 0);
    chk("no_ovf_sticky", 32'(ovf_sticky), 0);

    send(8'h10, 8'h01, 8'h0F, 1'b0);
    send(8'h64, 8'hCE, 8'h96, 1'b1);
    idle(2);
    chk("sticky_not_yet", 32'(ovf_sticky), 0);
    idle(1);
    chk("sticky_set", 32'(ovf_sticky), 1);
    chk("cnt_one", 32'(ovf_cnt), 1);

    send(8'h80, 8'h01, 8'h7F, 1'b1);
    send(8'h80, 8'h80, 8'h00, 1'b0);
    send(8'h37, 8'h37, 8'h00, 1'b0);
    send(8'h00, 8'h80, 8'h80, 1'b1);
    idle(4);
    chk("cnt_three", 32'(ovf_cnt), 3);

    // Back-to-back with one bubble; res_vld must mirror the issue pattern.
    pat_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    pat_a = '{8'h7F, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    pat_b = '{8'hFF, 8'h7F, 8'h00, 8'h02, 8'h00, 8'h00};
    pat_r = '{8'h80, 8'h80, 8'h00, 8'hFF, 8'h00, 8'h00};
    pat_o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) chk($sformatf("bubble_vld_%0d", i - 2), 32'(bif.res_vld), 32'(pat_v[i-2]));
      bif.arg_vld = pat_v[i];
      bif.a       = pat_a[i];
      bif.b       = pat_b[i];
      if (pat_v[i]) exp_q.push_back({pat_o[i], pat_r[i]});
    end
    idle(3);
    chk("cnt_four", 32'(ovf_cnt), 4);

    for (int i = 0; i < 20; i++) send(8'h80, 8'h01, 8'h7F, 1'b1);
    idle(4);
    chk("cnt_saturated", 32'(ovf_cnt), 15);
    chk("sticky_after_sat", 32'(ovf_sticky), 1);

    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_cleared", 32'(ovf_sticky), 0);
    chk("cnt_kept_on_clr", 32'(ovf_cnt), 15);

    // Clear lands on the same edge as the overflow event (k+2).
    send(8'h80, 8'h01, 8'h7F, 1'b1);
    idle(1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("set_beats_clr", 32'(ovf_sticky), 1);
    idle(3);

    // Reset one cycle after an accepted argument discards it.
    @(negedge clk);
    bif.arg_vld = 1'b1;
    bif.a       = 8'h80;
    bif.b       = 8'h01;
    @(negedge clk);
    bif.arg_vld = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("midrst_res_vld", 32'(bif.res_vld), 0);
    chk("midrst_res", 32'(bif.res), 0);
    chk("midrst_overflow", 32'(bif.overflow), 0);
    chk("midrst_sticky", 32'(ovf_sticky), 0);
    chk("midrst_cnt", 32'(ovf_cnt), 0);
    rst = 1'b0;
    idle(1);
    chk("midrst_no_vld", 32'(bif.res_vld), 0);
    idle(3);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
